uart_rx_word: RTL
=================

# uart_rx_word

Serial receiver paired with the word-wide UART transmitter on the same link. It deserialises 8N1 bytes from `rxd` at the same bit rate as the transmitter and packs four consecutive bytes, LSB-first, into one 32-bit word. The word is presented to the core through a single-entry valid/ready output register. It sits between the board's UART RX pin and the CPU's input port or loader.

## Interface
Parameters:
- `CLK_PER_HALF_BIT`, default 5208: clocks per half bit period; must match the transmitter. Minimum legal value is 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rdata`  out  32  assembled word; byte k occupies bits [8k+7:8k].
- `valid`  out  1  `rdata` holds an unconsumed word.
- `ready`  in  1  consumer accepts the word; transfer happens when `valid && ready`.
- `rx_busy`  out  1  high while a word is partially received (byte count ≠ 0, or a byte is in flight).
- `ferr`  out  1  one-cycle pulse on a framing error (stop bit sampled low).
- `overrun`  out  1  one-cycle pulse when a completed word is dropped because `valid` is still high.

## Operation
- `rxd` passes through a 2-flop synchronizer; all logic below uses the synchronized value `rxs`.
- Byte FSM states:
  - IDLE: `rxs == 0` → START, counter cleared.
  - START: when the counter reaches `CLK_PER_HALF_BIT-1` (mid start bit), `rxs == 0` → DATA with bit index 0. `rxs == 1` is a false start: return to IDLE with no error.
  - DATA: every `2*CLK_PER_HALF_BIT` clocks, sample `rxs` into the shift register, LSB first. After bit 7 → STOP.
  - STOP: after `2*CLK_PER_HALF_BIT` clocks (mid stop bit), sample once:
    - `rxs == 1`: the byte is good.
    - `rxs == 0`: pulse `ferr`, discard the partial word (byte count reset to 0).
  - STOP always returns to IDLE. A new start edge is accepted the next cycle; no wait for the end of the stop bit.
- Word assembly:
  - A 2-bit byte count selects the byte lane in the assembly register.
  - On the 4th good byte: if `valid == 0` or `ready == 1` (consumed the same cycle), the assembly register is copied to `rdata` and `valid` is set. Otherwise `overrun` pulses, the new word is dropped and the old `rdata` is kept.
  - The byte count wraps 3 → 0.
- `valid` is cleared on `valid && ready` unless a new word loads in the same cycle.
- Reset at any point, including mid-byte or mid-word, returns to IDLE: byte count 0, partial word discarded.
- Reset values: `rdata` = 0, `valid` = 0, `rx_busy` = 0, `ferr` = 0, `overrun` = 0. Synchronizer flops reset to 1.

## Timing
- Latency from the `rxd` falling edge to the data sample:
  - first data sample at 2 (sync) + `CLK_PER_HALF_BIT` + `2*CLK_PER_HALF_BIT` clocks;
  - each later bit at `+2*CLK_PER_HALF_BIT`.
- `valid` rises exactly one clock after the stop-bit sample of the 4th byte.
- `ferr` and `overrun` are high for exactly one clock, in the cycle after the stop sample.
- Tolerates the transmitter's shortened stop bit (0.9 bit) and back-to-back bytes.
- Bit counter is 32 bits wide and compares only for equality; no other arithmetic.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP);
  - helper constants for `e_clk_bit` (`2*CLK_PER_HALF_BIT-1`) and the half-bit compare value.
- Sub-module `uart_rx_byte` contains the synchronizer, the byte FSM and the bit counter. It outputs `byte_data[7:0]`, a `byte_ok` pulse and a `byte_ferr` pulse.
- Top `uart_rx_word` holds the byte count, assembly register, output register and handshake logic.

## Test plan
Run all scenarios with `CLK_PER_HALF_BIT = 4`.
- Bytes EF, BE, AD, DE sent back-to-back with `ready = 1` → one `valid` cycle with `rdata = 32'hDEADBEEF`; `ferr` and `overrun` stay 0.
- `rxd` glitches low for 3 clocks while idle → no byte is accepted, byte count stays 0, `rx_busy` stays 0.
- Byte 2 of a word sent with its stop bit low → one `ferr` pulse, no `valid`. A following clean word 12,34,56,78 → `rdata = 32'h78563412`.
- `ready = 0` while two words (11111111, then 22222222) arrive → `overrun` pulses once and `rdata` stays `32'h11111111`. Raising `ready` → one transfer, then `valid = 0`.
- `rst` asserted after 2 bytes of a word → all outputs return to reset values. Next word A0,B1,C2,D3 → `rdata = 32'hD3C2B1A0`.
- Loopback with the word-wide transmitter (`txd` → `rxd`) for 100 random words → every word is received in order and matches.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

    // Byte receiver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Terminal count of the bit counter for one full bit period.
    function automatic logic [31:0] e_clk_bit(input int unsigned half);
        return 32'(2 * half - 1);
    endfunction

    // Terminal count used to land in the middle of the start bit.
    function automatic logic [31:0] half_bit_cmp(input int unsigned half);
        return 32'(half - 1);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Deserialises one 8N1 byte from the asynchronous rxd pin.
// Latency: byte_ok/byte_ferr assert in the cycle the mid-stop sample is taken.
// Backpressure: none; the serial line cannot be stalled, pulses must be consumed at once.
import uart_pkg::*;

module uart_rx_byte #(
    parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_ok,
    output logic       byte_ferr,
    output logic       byte_busy
);

    localparam logic [31:0] BIT_END  = e_clk_bit(CLK_PER_HALF_BIT);
    localparam logic [31:0] HALF_END = half_bit_cmp(CLK_PER_HALF_BIT);

    logic        rx_meta;
    logic        rxs;
    rx_state_t   state;
    logic [31:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        stop_hit;

    // Two-flop synchronizer; resets to the idle (mark) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // Byte FSM: find start edge, confirm mid start bit, sample 8 data bits and the stop bit mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 32'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 32'd0;
                    if (!rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt <= 32'd0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            // Line went back high: a glitch, not a start bit.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= 32'd0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a shortened stop bit and an
                    // immediately following start edge are both caught.
                    if (cnt == BIT_END) begin
                        cnt   <= 32'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stop-bit sample outcome, valid for the single sampling cycle.
    always_comb begin
        stop_hit  = (state == STOP) && (cnt == BIT_END);
        byte_ok   = stop_hit && rxs;
        byte_ferr = stop_hit && !rxs;
        byte_data = shreg;
        byte_busy = (state == DATA) || (state == STOP);
    end

endmodule

// File: rtl/uart_rx_word.sv
// Packs four received bytes, LSB-first, into a 32-bit word behind a one-entry valid/ready register.
// Latency: valid rises one clock after the stop-bit sample of the 4th byte.
// Backpressure: a word completing while valid is held and ready is low is dropped with an overrun pulse.
import uart_pkg::*;

module uart_rx_word #(
    parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        ready,
    output logic        rx_busy,
    output logic        ferr,
    output logic        overrun
);

    logic [7:0]  byte_data;
    logic        byte_ok;
    logic        byte_ferr;
    logic        byte_busy;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;

    uart_rx_byte #(
        .CLK_PER_HALF_BIT (CLK_PER_HALF_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .byte_data (byte_data),
        .byte_ok   (byte_ok),
        .byte_ferr (byte_ferr),
        .byte_busy (byte_busy)
    );

    // Word assembly, output register, handshake and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            asm_word <= 24'd0;
            rdata    <= 32'd0;
            valid    <= 1'b0;
            ferr     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            ferr    <= 1'b0;
            overrun <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (byte_ferr) begin
                // A corrupted byte poisons the whole word: restart at lane 0.
                ferr     <= 1'b1;
                byte_cnt <= 2'd0;
            end else if (byte_ok) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: asm_word[7:0]   <= byte_data;
                    2'd1: asm_word[15:8]  <= byte_data;
                    2'd2: asm_word[23:16] <= byte_data;
                    default: begin
                        // Last lane goes straight to the output register.
                        if (!valid || ready) begin
                            rdata <= {byte_data, asm_word};
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Busy while a word is partly collected or a byte is being shifted in.
    always_comb begin
        rx_busy = byte_busy || (byte_cnt != 2'd0);
    end

endmodule
